// File: rtl/pipeline_ex_mem_stage_pkg.sv
// Shared types and codes for the execute stage: ID/EX and EX/MEM bundle layouts, ALU function and PC-source codes.
// Packed structs mirror the flat bus bit positions exactly (MSB first).
package pipeline_ex_mem_stage_pkg;

  typedef struct packed {
    logic        kmode;      // [148]
    logic [4:0]  rs;         // [147:143]
    logic [4:0]  rt;         // [142:138]
    logic [4:0]  addr_c;     // [137:133]
    logic [4:0]  shamt;      // [132:128]
    logic [31:0] lu_out;     // [127:96]
    logic [31:0] con_ba;     // [95:64]
    logic [31:0] bus_a;      // [63:32]
    logic [31:0] bus_b;      // [31:0]
  } idex_data_t;

  typedef struct packed {
    logic        valid;      // [17]
    logic        alu_src1;   // [16]
    logic        alu_src2;   // [15]
    logic [2:0]  pc_src;     // [14:12]
    logic [5:0]  alu_fun;    // [11:6]
    logic        sign;       // [5]
    logic        mem_wr;     // [4]
    logic        mem_rd;     // [3]
    logic        reg_wr;     // [2]
    logic [1:0]  mem_to_reg; // [1:0]
  } idex_ctrl_t;

  typedef struct packed {
    logic [4:0]  addr_c;     // [68:64]
    logic [31:0] alu_out;    // [63:32]
    logic [31:0] store_data; // [31:0]
  } exmem_data_t;

  typedef struct packed {
    logic        valid;
    logic        mem_wr;
    logic        mem_rd;
    logic        reg_wr;
    logic [1:0]  mem_to_reg;
  } exmem_ctrl_t;

  localparam logic [2:0] PCSRC_BRANCH = 3'b001;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // A register hit: enabled writer targets the source, and r0 never matches.
  function automatic logic reg_hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst == src) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_ex_mem_stage_alu.sv
// Combinational ALU: shifts move B by A[4:0], compares return a single flag in bit 0.
// Zero latency, no backpressure.
module cpu_alu
  import pipeline_ex_mem_stage_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  fun_i,
  input  logic        sign_i,
  output logic [31:0] z_o
);

  logic lt_flag;

  assign lt_flag = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  always_comb begin
    z_o = 32'd0;
    case (fun_i)
      ALU_ADD: z_o = a_i + b_i;
      ALU_SUB: z_o = a_i - b_i;
      ALU_AND: z_o = a_i & b_i;
      ALU_OR:  z_o = a_i | b_i;
      ALU_XOR: z_o = a_i ^ b_i;
      ALU_NOR: z_o = ~(a_i | b_i);
      ALU_A:   z_o = a_i;
      ALU_SLL: z_o = b_i << a_i[4:0];
      ALU_SRL: z_o = b_i >> a_i[4:0];
      ALU_SRA: z_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      ALU_EQ:  z_o = {31'd0, a_i == b_i};
      ALU_NEQ: z_o = {31'd0, a_i != b_i};
      ALU_LT:  z_o = {31'd0, lt_flag};
      ALU_LEZ: z_o = {31'd0, a_i[31] | (a_i == 32'd0)};
      ALU_LTZ: z_o = {31'd0, a_i[31]};
      ALU_GTZ: z_o = {31'd0, ~a_i[31] & (a_i != 32'd0)};
      default: z_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipeline_ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, load-use detection, EX/MEM register.
// One cycle ID/EX -> EX/MEM; EXMEM_Stall holds the register, a load-use hazard inserts one bubble.
module pipeline_ex_mem_stage
  import pipeline_ex_mem_stage_pkg::*;
#(
  parameter logic RESET_PC_KMODE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [148:0] IDEX_data,
  input  logic [17:0]  IDEX_control,
  input  logic         EXMEM_Stall,
  input  logic         MEMWB_RegWr,
  input  logic [4:0]   MEMWB_AddrC,
  input  logic [31:0]  MEMWB_Wdata,
  output logic [68:0]  EXMEM_data,
  output logic [5:0]   EXMEM_control,
  output logic         Branch_Taken,
  output logic [31:0]  Branch_Target,
  output logic         Flush_Upstream,
  output logic         EX_Stall
);

  idex_data_t  id;
  idex_ctrl_t  ic;
  exmem_data_t data_q, data_d;
  exmem_ctrl_t ctrl_q, ctrl_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;

  logic        ex_fwd_en;
  logic        load_use;
  logic [31:0] fwd_a, fwd_b;
  logic [31:0] alu_a, alu_b, alu_z;
  logic        unused_ok;

  assign id = IDEX_data;
  assign ic = IDEX_control;

  // A load in EX/MEM has no data yet; it can only reach us through MEM/WB next cycle.
  assign ex_fwd_en = ctrl_q.valid & ctrl_q.reg_wr & ~ctrl_q.mem_rd;

  assign fwd_a = reg_hit(ex_fwd_en, data_q.addr_c, id.rs)   ? data_q.alu_out :
                 reg_hit(MEMWB_RegWr, MEMWB_AddrC, id.rs)   ? MEMWB_Wdata    : id.bus_a;
  assign fwd_b = reg_hit(ex_fwd_en, data_q.addr_c, id.rt)   ? data_q.alu_out :
                 reg_hit(MEMWB_RegWr, MEMWB_AddrC, id.rt)   ? MEMWB_Wdata    : id.bus_b;

  assign load_use = ic.valid & ctrl_q.valid & ctrl_q.mem_rd &
                    (reg_hit(1'b1, data_q.addr_c, id.rs) | reg_hit(1'b1, data_q.addr_c, id.rt));

  assign alu_a = ic.alu_src1 ? {27'd0, id.shamt} : fwd_a;
  assign alu_b = ic.alu_src2 ? id.lu_out : fwd_b;

  cpu_alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .fun_i  (ic.alu_fun),
    .sign_i (ic.sign),
    .z_o    (alu_z)
  );

  always_comb begin
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    taken_d  = 1'b0;
    target_d = 32'd0;
    if (EXMEM_Stall) begin
      data_d = data_q;
      ctrl_d = ctrl_q;
    end else if (load_use || !ic.valid) begin
      data_d = '0;
      ctrl_d = '0;
    end else begin
      data_d = '{addr_c: id.addr_c, alu_out: alu_z, store_data: fwd_b};
      ctrl_d = '{valid: 1'b1, mem_wr: ic.mem_wr, mem_rd: ic.mem_rd,
                 reg_wr: ic.reg_wr, mem_to_reg: ic.mem_to_reg};
      if (ic.pc_src == PCSRC_BRANCH && alu_z[0]) begin
        taken_d  = 1'b1;
        target_d = id.con_ba;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign EXMEM_data     = data_q;
  assign EXMEM_control  = ctrl_q;
  assign Branch_Taken   = taken_q;
  assign Branch_Target  = target_q;
  assign Flush_Upstream = taken_q;
  assign EX_Stall       = load_use & ~EXMEM_Stall & ~reset;

  // Kernel-mode flag travels with the bundle but has no effect in this stage.
  assign unused_ok = ^{id.kmode, RESET_PC_KMODE};

endmodule
